pipelined_seg_adder: RTL and testbench
======================================

Name: pipelined_seg_adder

Overview:
- Parametrised, pipelined ripple-segment adder.
- Splits a WIDTH-bit add into NSEG = ceil(WIDTH/SEG) segments, one segment per pipeline stage, with the carry registered between stages.
- Sustains one add per cycle with a valid/ready handshake.
- Used in the multiplier datapath for partial-product accumulation and for mantissa/exponent sums where a flat ripple chain cannot meet timing.

Parameters:
- WIDTH, 64, operand and sum width in bits; must be >= 1.
- SEG, 16, segment width in bits, i.e. bits added per stage; 1 <= SEG <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset:
  - All stage valid bits clear; out_valid = 0, sum = 0, cout = 0; in_ready = 1 from the first cycle after reset deassertion.
  - Reset asserted mid-operation flushes all in-flight adds; none are emitted after reset.
- Segments:
  - Segment k covers bits [k*SEG +: SEG] for k < NSEG-1.
  - The last segment covers the remaining WIDTH-(NSEG-1)*SEG bits (1..SEG bits).
  - Each segment add is (SEGw+1) bits wide; the top bit is the carry to the next stage.
- Pipeline:
  - Stage k adds segment k of the operands with the registered carry from stage k-1.
  - Stage 0 uses cin.
  - Operand segments above k travel in skew registers.
  - Sum segments already computed travel in de-skew registers, so all sum bits leave aligned.
- Latency and throughput:
  - Latency is NSEG cycles: an operand pair accepted at edge t has out_valid = 1 after edge t+NSEG-1, provided there is no stall.
  - Throughput is one result per cycle.
- Handshake:
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - in_ready = !out_valid || out_ready (global stall).
  - When stalled, every pipeline register (data, carries, valid bits) holds.
  - Bubbles propagate as valid = 0 stages. Bubbles are not squeezed out.
  - Outputs stay stable while out_valid && !out_ready.
  - a, b and cin are ignored when in_valid = 0 or in_ready = 0.
- Boundaries:
  - WIDTH == SEG gives NSEG = 1: a single registered adder with latency 1.
  - All-ones + 1 wraps to zero with cout = 1.
  - Simultaneous out transfer and in transfer in the same cycle is legal and gives full throughput.

Optional Feature:
- Macro: PIPE_ADD_SUB_EN
- With the macro defined:
  - Extra input port sub (1 bit), sampled with the operands.
  - When sub = 1, stage logic uses ~b and forces the carry-in to 1, ignoring cin.
  - sum = a - b mod 2^WIDTH; cout = 1 means no borrow.
  - sub travels down the pipeline with its operands.
- Without the macro: no sub port; the block adds only.

Decomposition:
- Shared package pipe_add_pkg:
  - function nseg(WIDTH, SEG) returning ceil division.
  - function seg_lsb(k, SEG).
  - function seg_width(k, WIDTH, SEG).
- Natural sub-module: seg_add_stage, a combinational SEGw-bit add with carry in/out, parametrised by width and instantiated once per stage via generate.
- All pipeline registers stay in the top module.

Test Plan:
- Latency check, WIDTH=64, SEG=16, out_ready=1: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> out_valid exactly 4 cycles after accept, sum=0, cout=1.
- Back-to-back stream: (1,2,0), (64'h8000_0000_0000_0000, same, 1), (64'h0000_FFFF_0000_FFFF, 1, 1) on consecutive cycles -> sums 3/cout 0, 1/cout 1, 64'h0000_FFFF_0001_0001/cout 0 on consecutive cycles, in order.
- Backpressure: out_ready=0 for 3 cycles with 5 ops queued -> in_ready=0 while out_valid holds; sum stable; no result lost or duplicated after release; order preserved.
- Odd width, WIDTH=53, SEG=16 (NSEG=4, last segment 5 bits): a=2^53-1, b=2^52, cin=0 -> sum=2^52-1, cout=1, latency 4.
- Reset mid-flight: assert rst_n=0 with 3 ops in flight -> out_valid=0 immediately (asynchronous); after release, no stale result appears and the next op returns correctly.
- With PIPE_ADD_SUB_EN, WIDTH=64: a=5, b=7, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0; a=7, b=5, sub=1 -> sum=2, cout=1.

Source files
------------

// File: rtl/pipe_add_pkg.sv
// Shared helpers for the segmented pipelined adder: segment count and the
// bit position and width of each segment.
package pipe_add_pkg;

    function automatic int nseg(int width, int seg);
        return (width + seg - 1) / seg;
    endfunction

    function automatic int seg_lsb(int k, int seg);
        return k * seg;
    endfunction

    // Every segment is SEG bits wide except the last, which takes what is left.
    function automatic int seg_width(int k, int width, int seg);
        if (k == nseg(width, seg) - 1) begin
            return width - k * seg;
        end
        return seg;
    endfunction

endpackage

// File: rtl/seg_add_stage.sv
// Combinational W-bit add with carry in and carry out; one instance per
// pipeline stage of pipelined_seg_adder.
module seg_add_stage #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign s    = full[W-1:0];
    assign cout = full[W];

endmodule

// File: rtl/pipelined_seg_adder.sv
// Pipelined ripple-segment adder: one SEG-bit segment per stage, carry registered
// between stages. Define PIPE_ADD_SUB_EN to add the sub port (a - b).
module pipelined_seg_adder
    import pipe_add_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSEG = nseg(WIDTH, SEG);

    // Global stall: the whole pipe moves or the whole pipe holds.
    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    genvar gi;
    for (gi = 0; gi < NSEG; gi++) begin : g_stage
        localparam int LSB = seg_lsb(gi, SEG);
        localparam int SW  = seg_width(gi, WIDTH, SEG);
        localparam int REM = WIDTH - LSB - SW;

        // Operand bits not yet consumed, with this stage's segment at bit 0.
        logic [SW+REM-1:0] a_in;
        logic [SW+REM-1:0] b_in;
        logic              c_in;
        logic              v_in;
        logic              sub_in;
        logic [SW-1:0]     b_seg;
        logic [SW-1:0]     s_seg;
        logic              c_out;
        logic [LSB+SW-1:0] sum_next;
        logic [LSB+SW-1:0] sum_reg;
        logic              v_reg;
        logic              c_reg;

`ifdef PIPE_ADD_SUB_EN
        if (gi == 0) begin : g_sub_src
            assign sub_in = sub;
        end else begin : g_sub_src
            assign sub_in = g_stage[gi-1].g_skew.sub_reg;
        end
`else
        assign sub_in = 1'b0;
`endif

        if (gi == 0) begin : g_src
            assign a_in     = a;
            assign b_in     = b;
            assign v_in     = in_valid;
            assign c_in     = sub_in ? 1'b1 : cin;
            assign sum_next = s_seg;
        end else begin : g_src
            assign a_in     = g_stage[gi-1].g_skew.a_rem_reg;
            assign b_in     = g_stage[gi-1].g_skew.b_rem_reg;
            assign v_in     = g_stage[gi-1].v_reg;
            assign c_in     = g_stage[gi-1].c_reg;
            assign sum_next = {s_seg, g_stage[gi-1].sum_reg};
        end

        assign b_seg = b_in[SW-1:0] ^ {SW{sub_in}};

        seg_add_stage #(
            .W (SW)
        ) u_add (
            .a    (a_in[SW-1:0]),
            .b    (b_seg),
            .cin  (c_in),
            .s    (s_seg),
            .cout (c_out)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_reg   <= 1'b0;
                c_reg   <= 1'b0;
                sum_reg <= '0;
            end else if (advance) begin
                v_reg   <= v_in;
                c_reg   <= c_out;
                sum_reg <= sum_next;
            end
        end

        // Skew registers carry the untouched upper operand bits to later stages.
        if (gi < NSEG - 1) begin : g_skew
            logic [REM-1:0] a_rem_reg;
            logic [REM-1:0] b_rem_reg;
`ifdef PIPE_ADD_SUB_EN
            logic           sub_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sub_reg <= 1'b0;
                end else if (advance) begin
                    sub_reg <= sub_in;
                end
            end
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem_reg <= '0;
                    b_rem_reg <= '0;
                end else if (advance) begin
                    a_rem_reg <= a_in[SW+REM-1:SW];
                    b_rem_reg <= b_in[SW+REM-1:SW];
                end
            end
        end
    end

    assign out_valid = g_stage[NSEG-1].v_reg;
    assign sum       = g_stage[NSEG-1].sum_reg;
    assign cout      = g_stage[NSEG-1].c_reg;

endmodule

// File: tb/tb_pipelined_seg_adder.sv
// Bench for pipelined_seg_adder: 64/16 main instance with a queue-based model,
// plus 53/16 (odd width) and 8/8 (single stage) instances for directed checks.
module tb_pipelined_seg_adder;

    logic clk;
    logic rst_n;

    logic        m_in_valid, m_in_ready, m_cin, m_out_valid, m_out_ready, m_cout, m_sub;
    logic [63:0] m_a, m_b, m_sum;
    logic        o_in_valid, o_in_ready, o_cin, o_out_valid, o_cout, o_sub;
    logic [52:0] o_a, o_b, o_sum;
    logic        s_in_valid, s_in_ready, s_cin, s_out_valid, s_cout, s_sub;
    logic [7:0]  s_a, s_b, s_sum;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [64:0] v;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    bit          lat_next;
    logic        prev_stall;
    logic [63:0] prev_sum;
    logic        prev_cout;

    pipelined_seg_adder #(.WIDTH(64), .SEG(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .a(m_a), .b(m_b), .cin(m_cin),
`ifdef PIPE_ADD_SUB_EN
        .sub(m_sub),
`endif
        .out_valid(m_out_valid), .out_ready(m_out_ready), .sum(m_sum), .cout(m_cout)
    );

    pipelined_seg_adder #(.WIDTH(53), .SEG(16)) dut_odd (
        .clk(clk), .rst_n(rst_n), .in_valid(o_in_valid), .in_ready(o_in_ready),
        .a(o_a), .b(o_b), .cin(o_cin),
`ifdef PIPE_ADD_SUB_EN
        .sub(o_sub),
`endif
        .out_valid(o_out_valid), .out_ready(1'b1), .sum(o_sum), .cout(o_cout)
    );

    pipelined_seg_adder #(.WIDTH(8), .SEG(8)) dut_one (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin),
`ifdef PIPE_ADD_SUB_EN
        .sub(s_sub),
`endif
        .out_valid(s_out_valid), .out_ready(1'b1), .sum(s_sum), .cout(s_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer add, or subtract with cout meaning "no borrow".
    function automatic logic [64:0] ref64(logic [63:0] x, logic [63:0] y, logic c, logic s);
        if (s) return {x >= y, x - y};
        return {1'b0, x} + {1'b0, y} + {64'd0, c};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Called at a falling edge with inputs already driven; checks, then advances one cycle.
    task automatic tick(output bit acc);
        exp_t e;
        logic sub_now;
        #1;
`ifdef PIPE_ADD_SUB_EN
        sub_now = m_sub;
`else
        sub_now = 1'b0;
`endif
        total++;
        assert (m_in_ready === (!m_out_valid || m_out_ready))
        else begin bad++; $error("FAIL in_ready: got %b want %b", m_in_ready, !m_out_valid || m_out_ready); end
        if (prev_stall) begin
            total++;
            assert (m_out_valid === 1'b1 && m_sum === prev_sum && m_cout === prev_cout)
            else begin bad++; $error("FAIL stall_hold: got v=%b %h/%b want v=1 %h/%b", m_out_valid, m_sum, m_cout, prev_sum, prev_cout); end
        end
        if (m_out_valid && m_out_ready) begin
            total++;
            assert (q.size() != 0)
            else begin bad++; $error("FAIL extra_out: got %h/%b want no result", m_sum, m_cout); end
            if (q.size() != 0) begin
                e = q.pop_front();
                total++;
                assert ({m_cout, m_sum} === e.v)
                else begin bad++; $error("FAIL result: got %b/%h want %b/%h", m_cout, m_sum, e.v[64], e.v[63:0]); end
                if (e.lat) begin
                    total++;
                    assert (cyc - e.acc == 4)
                    else begin bad++; $error("FAIL latency: got %0d want 4", cyc - e.acc); end
                end
            end
        end
        acc = m_in_valid && m_in_ready;
        if (acc) begin
            e.v   = ref64(m_a, m_b, m_cin, sub_now);
            e.acc = cyc;
            e.lat = lat_next;
            q.push_back(e);
        end
        prev_stall = m_out_valid && !m_out_ready;
        prev_sum   = m_sum;
        prev_cout  = m_cout;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [63:0] x, input logic [63:0] y, input logic c, input logic s, input bit lat);
        bit acc;
        int n;
        m_a = x; m_b = y; m_cin = c; m_sub = s; m_in_valid = 1'b1; lat_next = lat;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            tick(acc);
            n++;
        end
        total++;
        assert (acc) else begin bad++; $error("FAIL send_timeout: got no accept want accept"); end
        m_in_valid = 1'b0; lat_next = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        m_in_valid = 1'b0; m_out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            tick(acc);
            n++;
        end
        total++;
        assert (q.size() == 0) else begin bad++; $error("FAIL drain: got %0d pending want 0", q.size()); end
    endtask

    task automatic run_o(input logic [52:0] x, input logic [52:0] y, input logic c);
        logic [53:0] e;
        int lat;
        e = {1'b0, x} + {1'b0, y} + {53'd0, c};
        o_a = x; o_b = y; o_cin = c; o_in_valid = 1'b1;
        #1;
        total++;
        assert (o_in_ready === 1'b1) else begin bad++; $error("FAIL odd_ready: got %b want 1", o_in_ready); end
        @(posedge clk); @(negedge clk);
        o_in_valid = 1'b0;
        lat = 1;
        while (o_out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        total++;
        assert (lat == 4) else begin bad++; $error("FAIL odd_latency: got %0d want 4", lat); end
        total++;
        assert ({o_cout, o_sum} === e) else begin bad++; $error("FAIL odd_result: got %b/%h want %b/%h", o_cout, o_sum, e[53], e[52:0]); end
    endtask

    task automatic run_s(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] e;
        int lat;
        e = {1'b0, x} + {1'b0, y} + {8'd0, c};
        s_a = x; s_b = y; s_cin = c; s_in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        s_in_valid = 1'b0;
        lat = 1;
        while (s_out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        total++;
        assert (lat == 1) else begin bad++; $error("FAIL one_latency: got %0d want 1", lat); end
        total++;
        assert ({s_cout, s_sum} === e) else begin bad++; $error("FAIL one_result: got %b/%h want %b/%h", s_cout, s_sum, e[8], e[7:0]); end
    endtask

    initial begin
        bit acc;
        int n;
        int stalls;
        rst_n = 1'b0;
        m_in_valid = 0; m_out_ready = 1; m_a = 0; m_b = 0; m_cin = 0; m_sub = 0;
        o_in_valid = 0; o_a = 0; o_b = 0; o_cin = 0; o_sub = 0;
        s_in_valid = 0; s_a = 0; s_b = 0; s_cin = 0; s_sub = 0;
        prev_stall = 0; prev_sum = 0; prev_cout = 0; lat_next = 0;

        repeat (2) @(negedge clk);
        #1;
        total++;
        assert (m_out_valid === 1'b0 && m_sum === 64'd0 && m_cout === 1'b0)
        else begin bad++; $error("FAIL reset_out: got %b/%h/%b want 0/0/0", m_out_valid, m_sum, m_cout); end
        total++;
        assert (o_out_valid === 1'b0 && s_out_valid === 1'b0)
        else begin bad++; $error("FAIL reset_valid_small: got %b%b want 00", o_out_valid, s_out_valid); end
        @(negedge clk);
        rst_n = 1'b1;

        // All-ones + 1 with latency check.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1);
        drain();

        // Back-to-back stream.
        send(64'd1, 64'd2, 1'b0, 1'b0, 1'b0);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0);
        send(64'h0000_FFFF_0000_FFFF, 64'd1, 1'b1, 1'b0, 1'b0);
        drain();

        // Backpressure: hold out_ready low for three stalled cycles with five ops pending.
        m_out_ready = 1'b0;
        n = 0;
        stalls = 0;
        for (int k = 0; k < 40 && n < 5; k++) begin
            m_in_valid = 1'b1; m_a = rnd64(); m_b = rnd64(); m_cin = 1'($urandom_range(0, 1)); m_sub = 1'b0;
            if (m_out_valid && !m_out_ready) begin
                #1;
                total++;
                assert (m_in_ready === 1'b0) else begin bad++; $error("FAIL bp_ready: got %b want 0", m_in_ready); end
                stalls++;
            end
            if (stalls >= 3) m_out_ready = 1'b1;
            tick(acc);
            if (acc) n++;
        end
        drain();

`ifdef PIPE_ADD_SUB_EN
        send(64'd5, 64'd7, 1'b0, 1'b1, 1'b0);
        send(64'd7, 64'd5, 1'b1, 1'b1, 1'b0);
        drain();
`endif

        // Random traffic with random backpressure and bubbles.
        for (int k = 0; k < 300; k++) begin
            m_in_valid  = ($urandom_range(0, 3) != 0);
            m_out_ready = ($urandom_range(0, 3) != 0);
            m_a   = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : rnd64();
            m_b   = ($urandom_range(0, 7) == 0) ? 64'd1 : rnd64();
            m_cin = 1'($urandom_range(0, 1));
`ifdef PIPE_ADD_SUB_EN
            m_sub = 1'($urandom_range(0, 1));
`endif
            tick(acc);
        end
        drain();
        m_sub = 1'b0;

        // Asynchronous reset with three ops in flight.
        m_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(rnd64(), rnd64(), 1'b0, 1'b0, 1'b0);
        tick(acc);
        #1;
        total++;
        assert (m_out_valid === 1'b1) else begin bad++; $error("FAIL pre_reset_valid: got %b want 1", m_out_valid); end
        #1 rst_n = 1'b0;
        #1;
        total++;
        assert (m_out_valid === 1'b0 && m_sum === 64'd0 && m_cout === 1'b0 && m_in_ready === 1'b1)
        else begin bad++; $error("FAIL async_reset: got %b/%h/%b rdy=%b want 0/0/0 rdy=1", m_out_valid, m_sum, m_cout, m_in_ready); end
        q.delete();
        prev_stall = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        m_out_ready = 1'b1;
        repeat (6) tick(acc);
        send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 1'b1);
        drain();

        // Odd width: last segment is 5 bits.
        run_o(53'h1F_FFFF_FFFF_FFFF, 53'h10_0000_0000_0000, 1'b0);
        run_o(53'($urandom) << 21 | 53'($urandom), 53'h1F_FFFF_FFFF_FFFF, 1'b1);

        // Single-stage configuration.
        run_s(8'hFF, 8'h01, 1'b0);
        run_s(8'($urandom), 8'($urandom), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
